ga_pe_pipe: RTL and testbench

//  Multi-lane, parametrised GA processing element: per lane, crossover of two parent genes then perturbation (bit-flip mutation).
//  2-stage pipeline with valid/ready handshakes, per-lane internal LFSRs and a selectable crossover mode.

---
 rtl/ga_pe_pkg.sv | 32 +++
 rtl/ga_lfsr32.sv | 25 ++
 rtl/ga_pe_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_ga_pe_pipe.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pe_pkg.sv
// Shared types, LFSR constants and seed helpers for the GA processing element.
package ga_pe_pkg;

    typedef enum logic [1:0] {
        CO_SINGLE  = 2'd0,
        CO_UNIFORM = 2'd1,
        CO_TWO     = 2'd2
    } ga_co_mode_e;

    localparam int unsigned LFSR_W      = 32;
    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    function automatic logic [LFSR_W-1:0] nonzero(input logic [LFSR_W-1:0] v);
        return (v == '0) ? 32'h1 : v;
    endfunction

    // Per-lane seed: crossover LFSR from base/stride, perturb LFSR is its complement
    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base,
                                                    input int unsigned lane,
                                                    input logic perturb);
        logic [LFSR_W-1:0] xl;
        xl = nonzero(base ^ (32'(lane) * SEED_STRIDE));
        return perturb ? nonzero(~xl) : xl;
    endfunction

endpackage

// File: rtl/ga_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (load wins over step).
module ga_lfsr32
    import ga_pe_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RESET_SEED;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/ga_pe_pipe.sv
// Multi-lane GA processing element: crossover (stage 1) then bit-flip perturbation (stage 2).
// Optional GA_PE_MUT_CNT_EN adds a saturating count of mutated lanes at the output handshake.
module ga_pe_pipe
    import ga_pe_pkg::*;
#(
    parameter int unsigned GENE_W    = 32,
    parameter int unsigned LANES     = 4,
    parameter int unsigned PROB_W    = 8,
    parameter logic [31:0] SEED_BASE = 32'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                cfg_mode,
    input  logic                      bias,
    input  logic [PROB_W-1:0]         co_prob,
    input  logic [PROB_W-1:0]         perturb_prob,
    input  logic                      seed_ld,
    input  logic [31:0]               seed,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*GENE_W-1:0]   parent0,
    input  logic [LANES*GENE_W-1:0]   parent1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*GENE_W-1:0]   child,
    output logic                      busy
`ifdef GA_PE_MUT_CNT_EN
   ,output logic [15:0]               mut_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(GENE_W);
    localparam int unsigned VEC_W = LANES * GENE_W;

    logic              ready_en;
    logic              s1_v;
    logic [VEC_W-1:0]  s1_vec;
    logic [PROB_W-1:0] s1_pprob;
    logic              accept;
    logic              s1_adv;
    logic              out_upd;
    logic              s1_v_nxt;
    logic              ov_nxt;
    logic [VEC_W-1:0]  co_vec;
    logic [VEC_W-1:0]  pt_vec;

    logic [31:0]       xl_state [LANES];
    logic [31:0]       pl_state [LANES];
    logic [GENE_W-1:0] co_gene  [LANES];
    logic [GENE_W-1:0] pt_gene  [LANES];

    // Crossover of one lane; mask bit set selects parent0
    function automatic logic [GENE_W-1:0] crossover(input logic [1:0]        mode,
                                                    input logic              sel1,
                                                    input logic [PROB_W-1:0] thr,
                                                    input logic [31:0]       x,
                                                    input logic [GENE_W-1:0] p0,
                                                    input logic [GENE_W-1:0] p1);
        logic [GENE_W-1:0] m;
        logic [IDX_W-1:0]  c;
        logic [IDX_W-1:0]  c2;
        logic [IDX_W-1:0]  lo;
        logic [IDX_W-1:0]  hi;
        m  = '0;
        c  = x[8 +: IDX_W];
        c2 = x[16 +: IDX_W];
        lo = (c < c2) ? c : c2;
        hi = (c < c2) ? c2 : c;
        for (int unsigned k = 0; k < GENE_W; k++) begin
            case (mode)
                2'(CO_UNIFORM): m[k] = x[k];
                2'(CO_TWO):     m[k] = !((k >= 32'(lo)) && (k < 32'(hi)));
                default:        m[k] = (k < 32'(c));
            endcase
        end
        if (x[PROB_W-1:0] < thr) begin
            return (p0 & m) | (p1 & ~m);
        end
        return sel1 ? p1 : p0;
    endfunction

    function automatic logic flip_hit(input logic [PROB_W-1:0] thr, input logic [31:0] p);
        return p[PROB_W-1:0] < thr;
    endfunction

    assign s1_adv   = s1_v && (!out_valid || out_ready);
    assign in_ready = ready_en && (!s1_v || s1_adv);
    assign accept   = in_valid && in_ready;
    assign out_upd  = !out_valid || out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [31:0] XL_SEED = lane_seed(SEED_BASE, i, 1'b0);
        localparam logic [31:0] PL_SEED = lane_seed(SEED_BASE, i, 1'b1);

        ga_lfsr32 #(.RESET_SEED(XL_SEED)) u_xl (
            .clk      (clk),
            .rst      (rst),
            .step     (accept),
            .load     (seed_ld),
            .load_val (lane_seed(seed, i, 1'b0)),
            .state    (xl_state[i])
        );

        ga_lfsr32 #(.RESET_SEED(PL_SEED)) u_pl (
            .clk      (clk),
            .rst      (rst),
            .step     (s1_adv),
            .load     (seed_ld),
            .load_val (lane_seed(seed, i, 1'b1)),
            .state    (pl_state[i])
        );

        assign co_gene[i] = crossover(cfg_mode, bias, co_prob, xl_state[i],
                                      parent0[i*GENE_W +: GENE_W], parent1[i*GENE_W +: GENE_W]);
        assign pt_gene[i] = s1_vec[i*GENE_W +: GENE_W]
                          ^ (GENE_W'(flip_hit(s1_pprob, pl_state[i])) << pl_state[i][8 +: IDX_W]);
    end

    always_comb begin
        co_vec = '0;
        pt_vec = '0;
        for (int k = 0; k < LANES; k++) begin
            co_vec[k*GENE_W +: GENE_W] = co_gene[k];
            pt_vec[k*GENE_W +: GENE_W] = pt_gene[k];
        end
    end

    always_comb begin
        s1_v_nxt = s1_v;
        ov_nxt   = out_valid;
        if (accept) begin
            s1_v_nxt = 1'b1;
        end else if (s1_adv) begin
            s1_v_nxt = 1'b0;
        end
        if (out_upd) begin
            ov_nxt = s1_v;
        end
    end

    // Stage 1: crossover result plus the captured perturbation threshold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
            s1_v     <= 1'b0;
            s1_vec   <= '0;
            s1_pprob <= '0;
        end else begin
            ready_en <= 1'b1;
            s1_v     <= s1_v_nxt;
            if (accept) begin
                s1_vec   <= co_vec;
                s1_pprob <= perturb_prob;
            end
        end
    end

    // Stage 2 / output register: holds while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            child     <= '0;
            busy      <= 1'b0;
        end else begin
            out_valid <= ov_nxt;
            busy      <= s1_v_nxt || ov_nxt;
            if (s1_adv) begin
                child <= pt_vec;
            end
        end
    end

`ifdef GA_PE_MUT_CNT_EN
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] mut_lanes;
    logic [16:0]      mut_sum;

    always_comb begin
        hits = '0;
        for (int k = 0; k < LANES; k++) begin
            hits = hits + CNT_W'(flip_hit(s1_pprob, pl_state[k]));
        end
        mut_sum = {1'b0, mut_cnt} + 17'(mut_lanes);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mut_lanes <= '0;
            mut_cnt   <= '0;
        end else begin
            if (s1_adv) begin
                mut_lanes <= hits;
            end
            if (out_valid && out_ready) begin
                mut_cnt <= mut_sum[16] ? 16'hFFFF : mut_sum[15:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ga_pe_pipe.sv
// Scoreboard bench for ga_pe_pipe: an independent lane model predicts each child at accept time.
module tb_ga_pe_pipe;

    localparam int unsigned GW = 32;
    localparam int unsigned LN = 4;
    localparam int unsigned VW = GW * LN;
    localparam logic [31:0] BASE = 32'hACE1;

    typedef struct packed {
        logic [VW-1:0] child;
        logic [7:0]    hits;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [1:0]    cfg_mode;
    logic          bias;
    logic [7:0]    co_prob;
    logic [7:0]    perturb_prob;
    logic          seed_ld;
    logic [31:0]   seed;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] parent0;
    logic [VW-1:0] parent1;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] child;
    logic          busy;
`ifdef GA_PE_MUT_CNT_EN
    logic [15:0]   mut_cnt;
`endif

    ga_pe_pipe #(.GENE_W(GW), .LANES(LN), .PROB_W(8), .SEED_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mode     (cfg_mode),
        .bias         (bias),
        .co_prob      (co_prob),
        .perturb_prob (perturb_prob),
        .seed_ld      (seed_ld),
        .seed         (seed),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .parent0      (parent0),
        .parent1      (parent1),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .child        (child),
        .busy         (busy)
`ifdef GA_PE_MUT_CNT_EN
       ,.mut_cnt      (mut_cnt)
`endif
    );

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] xl_m [LN];
    logic [31:0] pl_m [LN];
    int          exp_mut = 0;
    int          acc_cnt = 0;
    int          bp_mode = 0;
    logic [VW-1:0] first_exp;
    bit          bg_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic model_seed(input logic [31:0] base);
        logic [31:0] li;
        logic [31:0] v;
        for (int i = 0; i < LN; i++) begin
            li = 32'(i);
            v = base ^ (li * 32'h9E37_79B9);
            if (v == 32'd0) v = 32'd1;
            xl_m[i] = v;
            v = ~v;
            if (v == 32'd0) v = 32'd1;
            pl_m[i] = v;
        end
    endtask

    task automatic model_accept(output exp_t e);
        logic [31:0] x, p, a, b, g, r;
        logic [63:0] m;
        int c, c2, lo, hi, h;
        h = 0;
        e = '0;
        for (int i = 0; i < LN; i++) begin
            x = xl_m[i];
            p = pl_m[i];
            a = parent0[i*GW +: GW];
            b = parent1[i*GW +: GW];
            c  = int'(x[15:8]) % 32;
            c2 = int'(x[23:16]) % 32;
            if (x[7:0] < co_prob) begin
                if (cfg_mode == 2'd1) begin
                    g = (a & x) | (b & ~x);
                end else if (cfg_mode == 2'd2) begin
                    lo = (c < c2) ? c : c2;
                    hi = (c < c2) ? c2 : c;
                    m = ((64'd1 << hi) - 64'd1) ^ ((64'd1 << lo) - 64'd1);
                    r = m[31:0];
                    g = (b & r) | (a & ~r);
                end else begin
                    m = (64'd1 << c) - 64'd1;
                    g = (a & m[31:0]) | (b & ~m[31:0]);
                end
            end else begin
                g = bias ? b : a;
            end
            if (p[7:0] < perturb_prob) begin
                g = g ^ (32'd1 << (int'(p[15:8]) % 32));
                h++;
            end
            e.child[i*GW +: GW] = g;
            xl_m[i] = m_step(x);
            pl_m[i] = m_step(p);
        end
        e.hits = 8'(h);
    endtask

    // Consumer side of the scoreboard plus model update on accept / reseed
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid && out_ready) begin
                check_val("sb_avail", VW'(exp_q.size() > 0), VW'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("child", child, e.child);
                    exp_mut = exp_mut + int'(e.hits);
                    if (exp_mut > 65535) exp_mut = 65535;
                end
            end
            if (seed_ld) begin
                model_seed(seed);
            end else if (in_valid && in_ready) begin
                model_accept(e);
                exp_q.push_back(e);
                acc_cnt++;
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] md,
                        input logic bs, input logic [7:0] cp, input logic [7:0] pp);
        int n;
        parent0 = a; parent1 = b; cfg_mode = md; bias = bs; co_prob = cp; perturb_prob = pp;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("send_ready", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bp_mode = 0;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("drain_empty", VW'(exp_q.size()), VW'(0));
    endtask

    task automatic reseed(input logic [31:0] v);
        seed = v;
        seed_ld = 1'b1;
        @(posedge clk);
        #1;
        seed_ld = 1'b0;
    endtask

    task automatic replay_block();
        logic [31:0] w;
        for (int k = 0; k < 12; k++) begin
            w = 32'(k) * 32'h0101_0101 + 32'h1357_9BDF;
            send({4{w}}, {4{~w ^ 32'h00FF_00FF}}, 2'(k % 4), 1'(k % 2), 8'hC0, 8'h90);
        end
        drain();
    endtask

    localparam logic [VW-1:0] A0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [VW-1:0] A1 = 128'hDEAD_BEEF_CAFE_F00D_0F1E_2D3C_4B5A_6978;

    initial begin
        int edges;
        int acc0;
        int n;
        rst = 1'b0; in_valid = 1'b0; seed_ld = 1'b0; seed = '0; out_ready = 1'b1;
        cfg_mode = '0; bias = 1'b0; co_prob = '0; perturb_prob = '0; parent0 = '0; parent1 = '0;
        model_seed(BASE);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", VW'(in_ready), VW'(0));
        check_val("rst_out_valid", VW'(out_valid), VW'(0));
        check_val("rst_busy", VW'(busy), VW'(0));
        check_val("rst_child", child, VW'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("post_rst_in_ready", VW'(in_ready), VW'(1));
`ifdef GA_PE_MUT_CNT_EN
        check_val("rst_mut_cnt", VW'(mut_cnt), VW'(0));
`endif

        // Reference item from a fresh reset
        send(A0, A1, 2'd1, 1'b0, 8'hFF, 8'h80);
        first_exp = exp_q[$].child;
        drain();

        // Copy of parent1 with no crossover/mutation; two-edge latency
        parent0 = {4{32'hAAAA_AAAA}}; parent1 = {4{32'h5555_5555}};
        cfg_mode = 2'd0; bias = 1'b1; co_prob = 8'h00; perturb_prob = 8'h00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check_val("t1_latency", VW'(edges), VW'(2));
        check_val("t1_child", child, {4{32'h5555_5555}});
        drain();

        // Pure mutation stream
        for (int k = 0; k < 64; k++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 2'd0, 1'b0, 8'h00, 8'hFF);
        end
        drain();
`ifdef GA_PE_MUT_CNT_EN
        check_val("mut_cnt", VW'(mut_cnt), VW'(exp_mut));
`endif

        // Forced crossover, single-point and two-point, no mutation
        for (int k = 0; k < 8; k++) send('0, '1, 2'd0, 1'b0, 8'hFF, 8'h00);
        for (int k = 0; k < 8; k++) send('0, '1, 2'd2, 1'b0, 8'hFF, 8'h00);
        for (int k = 0; k < 4; k++) send('0, '1, 2'd3, 1'b1, 8'hFF, 8'h00);
        drain();

        // Backpressure: two items in flight, third blocked, output held
        bp_mode = 1;
        acc0 = acc_cnt;
        bg_done = 1'b0;
        fork
            begin
                send(A0, A1, 2'd0, 1'b0, 8'h80, 8'h40);
                send(A1, A0, 2'd1, 1'b1, 8'h80, 8'h40);
                send(A0, ~A1, 2'd2, 1'b0, 8'h80, 8'h40);
                bg_done = 1'b1;
            end
        join_none
        repeat (5) @(posedge clk);
        #3;
        check_val("t4_in_ready", VW'(in_ready), VW'(0));
        check_val("t4_out_valid", VW'(out_valid), VW'(1));
        check_val("t4_busy", VW'(busy), VW'(1));
        check_val("t4_accepts", VW'(acc_cnt - acc0), VW'(2));
        check_val("t4_hold_child", child, exp_q[0].child);
        bp_mode = 0;
        n = 0;
        while (!bg_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("t4_bg_done", VW'(bg_done), VW'(1));
        drain();

        // Random configuration under random backpressure
        bp_mode = 2;
        for (int k = 0; k < 40; k++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        drain();

        // Reseeding: replay twice from the same seed, then an all-zero seed
        reseed(32'h1234);
        replay_block();
        reseed(32'h1234);
        replay_block();
        reseed(32'h0);
        for (int k = 0; k < 8; k++) send(A0, A1, 2'(k % 3), 1'b0, 8'hFF, 8'hFF);
        drain();

        // Asynchronous reset with a valid output pending
        bp_mode = 1;
        send(A1, A0, 2'd0, 1'b0, 8'h80, 8'h80);
        send(A0, A1, 2'd1, 1'b1, 8'h80, 8'h80);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_out_valid", VW'(out_valid), VW'(0));
        check_val("t6_child", child, VW'(0));
        check_val("t6_busy", VW'(busy), VW'(0));
        check_val("t6_in_ready", VW'(in_ready), VW'(0));
        exp_q.delete();
        model_seed(BASE);
        exp_mut = 0;
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(A0, A1, 2'd1, 1'b0, 8'hFF, 8'h80);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("t6_replay", child, first_exp);
        drain();
`ifdef GA_PE_MUT_CNT_EN
        check_val("t6_mut_cnt", VW'(mut_cnt), VW'(exp_mut));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
